// File: rtl/writeback_queue.sv
// writeback_queue: in-order result FIFO that drains into the register bank, with an operand hazard check.
// Define WBQ_FORWARD_EN to forward pending results to the operands instead of raising src_stall.
module writeback_queue #(
   parameter int DW = 16,
   parameter int AW = 3,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_valid,
   input  logic [AW-1:0]          wb_dest,
   input  logic [DW-1:0]          wb_data,
   output logic                   wb_ready,
   input  logic                   rb_busy,
   output logic                   reg_write,
   output logic [AW-1:0]          destreg_sel,
   output logic [DW-1:0]          ALU_result,
   input  logic [AW-1:0]          srcreg1_sel,
   input  logic [AW-1:0]          srcreg2_sel,
   input  logic [DW-1:0]          rb_srcreg1,
   input  logic [DW-1:0]          rb_srcreg2,
   output logic [DW-1:0]          srcreg1,
   output logic [DW-1:0]          srcreg2,
   output logic                   src_stall,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [AW-1:0] dest_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] head, tail;
   logic [AW-1:0] last_dest;
   logic [DW-1:0] last_data;
   logic          push, empty;
   assign empty       = count == '0;
   assign wb_ready    = count < CW'(DEPTH);
   assign push        = wb_valid && wb_ready;
   assign reg_write   = !empty && !rb_busy;
   // once drained, the bank port keeps showing the entry it last wrote
   assign destreg_sel = empty ? last_dest : dest_q[head];
   assign ALU_result  = empty ? last_data : data_q[head];
   always_ff @(posedge clk)
      if (push) begin
         dest_q[tail] <= wb_dest;
         data_q[tail] <= wb_data;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         last_dest <= '0;
         last_data <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (reg_write) begin
            head      <= head + PW'(1);
            last_dest <= dest_q[head];
            last_data <= data_q[head];
         end
         count <= count + CW'(push) - CW'(reg_write);
      end
   // scan oldest to youngest so the youngest matching entry wins
   always_comb begin
      srcreg1   = rb_srcreg1;
      srcreg2   = rb_srcreg2;
      src_stall = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) < count) begin
`ifdef WBQ_FORWARD_EN
            if (dest_q[head + PW'(i)] == srcreg1_sel) srcreg1 = data_q[head + PW'(i)];
            if (dest_q[head + PW'(i)] == srcreg2_sel) srcreg2 = data_q[head + PW'(i)];
`else
            if (dest_q[head + PW'(i)] == srcreg1_sel || dest_q[head + PW'(i)] == srcreg2_sel)
               src_stall = 1'b1;
`endif
         end
   end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed table, corner-case sequences and a queue-model random run for writeback_queue.
module tb_writeback_queue;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int DEPTH = 4;

   logic          clk = 0, reset = 0;
   logic          wb_valid = 0, rb_busy = 0;
   logic [AW-1:0] wb_dest = 0, srcreg1_sel = 0, srcreg2_sel = 0;
   logic [DW-1:0] wb_data = 0, rb_srcreg1 = 0, rb_srcreg2 = 0;
   logic          wb_ready, reg_write, src_stall;
   logic [AW-1:0] destreg_sel;
   logic [DW-1:0] ALU_result, srcreg1, srcreg2;
   logic [$clog2(DEPTH):0] count;

   writeback_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .wb_ready(wb_ready), .rb_busy(rb_busy), .reg_write(reg_write), .destreg_sel(destreg_sel),
      .ALU_result(ALU_result), .srcreg1_sel(srcreg1_sel), .srcreg2_sel(srcreg2_sel),
      .rb_srcreg1(rb_srcreg1), .rb_srcreg2(rb_srcreg2), .srcreg1(srcreg1), .srcreg2(srcreg2),
      .src_stall(src_stall), .count(count));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] d;
      logic [DW-1:0] x;
   } ent_t;

   typedef struct {
      logic          v;
      logic [AW-1:0] d;
      logic [DW-1:0] x;
      logic          busy;
      logic          e_ready;
      logic          e_rw;
      logic [AW-1:0] e_dsel;
      logic [DW-1:0] e_res;
      int            e_cnt;
   } vec_t;

   int   tests = 0, fails = 0;
   ent_t wlog[$];
   ent_t mq[$];
   ent_t last;
   vec_t tbl[20];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // record a bank write seen before the edge, then advance one cycle
   task automatic tick();
      if (reg_write) wlog.push_back('{destreg_sel, ALU_result});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wb_valid = 0;
      rb_busy = 0;
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      mq.delete();
      last = '0;
   endtask

   task automatic offer(input logic [AW-1:0] d, input logic [DW-1:0] x, input logic busy);
      wb_valid = 1;
      wb_dest = d;
      wb_data = x;
      rb_busy = busy;
      #1;
      tick();
      wb_valid = 0;
   endtask

   function automatic void lookup(input logic [AW-1:0] sel, input logic [DW-1:0] raw,
                                  output logic [DW-1:0] val, output logic hit);
      hit = 0;
      val = raw;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (!hit && mq[i].d == sel) begin
            hit = 1;
            val = mq[i].x;
         end
   endfunction

   initial begin
      logic          e_ready, e_rw, h1, h2, acc;
      logic [DW-1:0] v1, v2;
      ent_t          e_head;
      int            guard;

      tbl[0]  = '{1, 3, 16'h0F0F, 0, 1, 0, 0, 16'h0000, 0};
      tbl[1]  = '{0, 0, 16'h0000, 0, 1, 1, 3, 16'h0F0F, 1};
      tbl[2]  = '{0, 0, 16'h0000, 1, 1, 0, 3, 16'h0F0F, 0};
      tbl[3]  = '{1, 1, 16'h0101, 1, 1, 0, 3, 16'h0F0F, 0};
      tbl[4]  = '{1, 2, 16'h0202, 1, 1, 0, 1, 16'h0101, 1};
      tbl[5]  = '{1, 4, 16'h0404, 1, 1, 0, 1, 16'h0101, 2};
      tbl[6]  = '{1, 6, 16'h0606, 1, 1, 0, 1, 16'h0101, 3};
      tbl[7]  = '{1, 7, 16'h0707, 1, 0, 0, 1, 16'h0101, 4};
      tbl[8]  = '{1, 7, 16'h0707, 0, 0, 1, 1, 16'h0101, 4};
      tbl[9]  = '{0, 0, 16'h0000, 0, 1, 1, 2, 16'h0202, 3};
      tbl[10] = '{0, 0, 16'h0000, 0, 1, 1, 4, 16'h0404, 2};
      tbl[11] = '{0, 0, 16'h0000, 0, 1, 1, 6, 16'h0606, 1};
      tbl[12] = '{0, 0, 16'h0000, 0, 1, 0, 6, 16'h0606, 0};
      tbl[13] = '{1, 1, 16'h00A1, 1, 1, 0, 6, 16'h0606, 0};
      tbl[14] = '{1, 2, 16'h00A2, 1, 1, 0, 1, 16'h00A1, 1};
      tbl[15] = '{1, 3, 16'h00A3, 0, 1, 1, 1, 16'h00A1, 2};
      tbl[16] = '{0, 0, 16'h0000, 1, 1, 0, 2, 16'h00A2, 2};
      tbl[17] = '{0, 0, 16'h0000, 0, 1, 1, 2, 16'h00A2, 2};
      tbl[18] = '{0, 0, 16'h0000, 0, 1, 1, 3, 16'h00A3, 1};
      tbl[19] = '{0, 0, 16'h0000, 0, 1, 0, 3, 16'h00A3, 0};

      // reset values while reset is held
      #1 reset = 1;
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_reg_write", 32'(reg_write), 0);
      chk("rst_wb_ready", 32'(wb_ready), 1);
      chk("rst_destreg_sel", 32'(destreg_sel), 0);
      chk("rst_ALU_result", 32'(ALU_result), 0);
      chk("rst_src_stall", 32'(src_stall), 0);
      @(posedge clk);
      #1 reset = 0;

      // single write, fill/full, simultaneous enqueue/dequeue
      for (int r = 0; r < 20; r++) begin
         wb_valid = tbl[r].v;
         wb_dest = tbl[r].d;
         wb_data = tbl[r].x;
         rb_busy = tbl[r].busy;
         #1;
         chk($sformatf("tbl%0d_wb_ready", r), 32'(wb_ready), 32'(tbl[r].e_ready));
         chk($sformatf("tbl%0d_reg_write", r), 32'(reg_write), 32'(tbl[r].e_rw));
         chk($sformatf("tbl%0d_destreg_sel", r), 32'(destreg_sel), 32'(tbl[r].e_dsel));
         chk($sformatf("tbl%0d_ALU_result", r), 32'(ALU_result), 32'(tbl[r].e_res));
         chk($sformatf("tbl%0d_count", r), 32'(count), 32'(tbl[r].e_cnt));
         tick();
      end
      wb_valid = 0;

      // forwarding / stall on the youngest matching entry
      do_reset();
      offer(5, 16'h1111, 1);
      offer(5, 16'h2222, 1);
      srcreg1_sel = 5;
      rb_srcreg1 = 16'hAAAA;
      srcreg2_sel = 2;
      rb_srcreg2 = 16'hBBBB;
      #1;
`ifdef WBQ_FORWARD_EN
      chk("fwd_srcreg1", 32'(srcreg1), 32'h2222);
      chk("fwd_src_stall", 32'(src_stall), 0);
`else
      chk("fwd_srcreg1", 32'(srcreg1), 32'hAAAA);
      chk("fwd_src_stall", 32'(src_stall), 1);
`endif
      chk("fwd_srcreg2", 32'(srcreg2), 32'hBBBB);
      srcreg1_sel = 6;
      #1;
      chk("nomatch_srcreg1", 32'(srcreg1), 32'hAAAA);
      chk("nomatch_src_stall", 32'(src_stall), 0);
      srcreg1_sel = 0;
      srcreg2_sel = 0;

      // mid-operation reset with three pending entries
      do_reset();
      offer(1, 16'h0011, 1);
      offer(2, 16'h0022, 1);
      offer(3, 16'h0033, 1);
      chk("mid_pre_count", 32'(count), 3);
      rb_busy = 0;
      reset = 1;
      #1;
      chk("mid_count", 32'(count), 0);
      chk("mid_reg_write", 32'(reg_write), 0);
      chk("mid_wb_ready", 32'(wb_ready), 1);
      chk("mid_destreg_sel", 32'(destreg_sel), 0);
      @(posedge clk);
      #1 reset = 0;
      wlog.delete();
      for (int c = 0; c < 4; c++) begin
         #1;
         tick();
      end
      chk("mid_stale_writes", 32'(wlog.size()), 0);
      chk("mid_post_count", 32'(count), 0);

      // wrap: 10 results offered back to back while rb_busy toggles
      do_reset();
      wlog.delete();
      for (int k = 1; k <= 10; k++) begin
         wb_valid = 1;
         wb_dest = AW'(k);
         wb_data = DW'(k);
         acc = 0;
         guard = 0;
         while (!acc && guard < 20) begin
            rb_busy = ~rb_busy;
            #1;
            acc = wb_ready;
            tick();
            guard++;
         end
         if (!acc) chk($sformatf("wrap_accept_%0d", k), 0, 1);
      end
      wb_valid = 0;
      rb_busy = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         tick();
      end
      chk("wrap_write_count", 32'(wlog.size()), 10);
      for (int k = 0; k < 10 && k < wlog.size(); k++)
         chk($sformatf("wrap_write_%0d", k + 1), 32'(wlog[k].x), 32'(k + 1));

      // randomized run against the queue model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         wb_valid = $urandom_range(0, 9) < 7;
         wb_dest = AW'($urandom);
         wb_data = DW'($urandom);
         rb_busy = $urandom_range(0, 9) < 4;
         srcreg1_sel = AW'($urandom);
         srcreg2_sel = AW'($urandom);
         rb_srcreg1 = DW'($urandom);
         rb_srcreg2 = DW'($urandom);
         #1;
         e_ready = mq.size() < DEPTH;
         e_rw = mq.size() > 0 && !rb_busy;
         e_head = mq.size() > 0 ? mq[0] : last;
         lookup(srcreg1_sel, rb_srcreg1, v1, h1);
         lookup(srcreg2_sel, rb_srcreg2, v2, h2);
         chk("rnd_wb_ready", 32'(wb_ready), 32'(e_ready));
         chk("rnd_reg_write", 32'(reg_write), 32'(e_rw));
         chk("rnd_destreg_sel", 32'(destreg_sel), 32'(e_head.d));
         chk("rnd_ALU_result", 32'(ALU_result), 32'(e_head.x));
         chk("rnd_count", 32'(count), 32'(mq.size()));
`ifdef WBQ_FORWARD_EN
         chk("rnd_srcreg1", 32'(srcreg1), 32'(v1));
         chk("rnd_srcreg2", 32'(srcreg2), 32'(v2));
         chk("rnd_src_stall", 32'(src_stall), 0);
`else
         chk("rnd_srcreg1", 32'(srcreg1), 32'(rb_srcreg1));
         chk("rnd_srcreg2", 32'(srcreg2), 32'(rb_srcreg2));
         chk("rnd_src_stall", 32'(src_stall), 32'(h1 | h2));
`endif
         if (e_rw) last = mq.pop_front();
         if (wb_valid && e_ready) mq.push_back('{wb_dest, wb_data});
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DW, 16, data width of ALU results and register contents.
REQ-002 SHALL have parameter AW, 3, register select width (8 registers).
REQ-003 SHALL have parameter DEPTH, 4, queue entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wb_valid  input  1  producer offers a result.
REQ-007 SHALL have port wb_dest  input  AW  destination register of offered result.
REQ-008 SHALL have port wb_data  input  DW  offered result value.
REQ-009 SHALL have port wb_ready  output  1  queue can accept an offered result this cycle.
REQ-010 SHALL have port rb_busy  input  1  register bank write port unavailable this cycle.
REQ-011 SHALL have port reg_write  output  1  write strobe to register bank.
REQ-012 SHALL have port destreg_sel  output  AW  register bank write select.
REQ-013 SHALL have port ALU_result  output  DW  register bank write data.
REQ-014 SHALL have ports srcreg1_sel, srcreg2_sel  input  AW each  operand read selects.
REQ-015 SHALL have ports rb_srcreg1, rb_srcreg2  input  DW each  raw register bank read data.
REQ-016 SHALL have ports srcreg1, srcreg2  output  DW each  operand values seen by the consumer.
REQ-017 SHALL have port src_stall  output  1  operand read hits a pending write and cannot be served.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 SHALL drive wb_ready = 1 iff count < DEPTH; no same-cycle pass-through when full, even if a dequeue occurs.
REQ-020 SHALL enqueue {wb_dest, wb_data} at the tail on a rising edge where wb_valid && wb_ready.
REQ-021 SHALL drive reg_write = 1 iff count > 0 && !rb_busy, combinationally.
REQ-022 SHALL drive destreg_sel/ALU_result from the head entry at all times; when empty, they hold the last head contents (0 after reset).
REQ-023 SHALL pop the head on every rising edge where reg_write = 1.
REQ-024 SHALL give latency: an entry enqueued at edge N is presentable at head no earlier than the cycle after edge N (no combinational wb_* to reg_write path).
REQ-025 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and keep FIFO order.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH without loss or duplication.
REQ-027 SHALL treat all registers, including register 0, as ordinary targets.
REQ-028 SHALL, for each operand port, find the youngest pending entry (head..tail-1) whose dest equals the select; the entry being written this cycle counts as pending.
REQ-029 SHALL drive srcregN = rb_srcregN when no pending entry matches.
REQ-030 SHALL keep every output hazard-free with respect to the operand inputs (purely combinational, no added state).

Reset
REQ-031 SHALL, while reset is high, clear count and both pointers and drive reg_write = 0, wb_ready = 1, destreg_sel = 0, ALU_result = 0, src_stall = 0.
REQ-032 SHALL discard all pending writes when reset asserts mid-operation; no partial write is issued.

Configuration
REQ-033 SHALL support macro WBQ_FORWARD_EN: when defined, a matching operand gets the youngest matching entry's data on srcregN and src_stall is constant 0.
REQ-034 SHALL, without WBQ_FORWARD_EN, drive srcregN = rb_srcregN always and src_stall = 1 iff either select matches any pending entry.

Verification
REQ-035 SHALL cover single write: enqueue dest=3, data=0x0F0F, rb_busy=0 -> next cycle reg_write=1, destreg_sel=3, ALU_result=0x0F0F; then count=0.
REQ-036 SHALL cover fill/full: rb_busy=1, enqueue 4 entries -> count=4, wb_ready=0; 5th offer not accepted; release rb_busy -> 4 writes in order on consecutive cycles.
REQ-037 SHALL cover wrap: 10 back-to-back enqueues of data 1..10 with rb_busy toggling -> bank writes occur in order 1..10, none lost or duplicated.
REQ-038 SHALL cover forwarding: pending dest=5 data=0x1111 then dest=5 data=0x2222, srcreg1_sel=5, rb_srcreg1=0xAAAA -> srcreg1=0x2222 with WBQ_FORWARD_EN; without it, srcreg1=0xAAAA and src_stall=1.
REQ-039 SHALL cover mid-operation reset: 3 pending entries, assert reset -> count=0, reg_write=0 immediately; after release, no stale writes issue.
REQ-040 SHALL cover simultaneous enqueue/dequeue at count=2 -> count stays 2, order preserved.
